// File: rtl/sweep_sequencer_pkg.sv
// Shared definitions for the RF-frontend sweep sequencer: FSM encoding,
// register offsets relative to BASE_ADDR, and the VCO lock timeout.
package sweep_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_DWELL     = 3'd4,
        ST_NEXT      = 3'd5
    } state_t;

    localparam logic [6:0] REG_CTRL   = 7'd0;
    localparam logic [6:0] REG_SETTLE = 7'd1;
    localparam logic [6:0] REG_DWELL  = 7'd2;
    localparam logic [6:0] REG_NSTEPS = 7'd3;
    localparam logic [6:0] REG_TABLE  = 7'd4;

    localparam logic [15:0] LOCK_TIMEOUT = 16'hFFFF;

    // Zero steps still runs one step; requests beyond the table depth are clamped.
    function automatic logic [3:0] clamp_nsteps(input logic [3:0] n, input logic [3:0] max_n);
        if (n == 4'd0)
            return 4'd1;
        else if (n > max_n)
            return max_n;
        else
            return n;
    endfunction

endpackage

// File: rtl/sweep_step_table.sv
// Step table: NSTEPS entries of 6-bit RF-frontend selects, written over the
// serial register bus, with one combinational read port indexed by step.
module sweep_step_table
    import sweep_sequencer_pkg::*;
#(
    parameter logic [6:0] BASE_ADDR = 7'd80,
    parameter int         NSTEPS    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic [3:0] rd_idx,
    output logic [5:0] rd_data
);

    logic [5:0] sel_data [NSTEPS];

    generate
        for (genvar gi = 0; gi < NSTEPS; gi++) begin : g_entry
            localparam logic [6:0] ENTRY_ADDR = BASE_ADDR + REG_TABLE + 7'(gi);
            logic [5:0] entry_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    entry_reg <= 6'd0;
                else if (wr_en && (wr_addr == ENTRY_ADDR))
                    entry_reg <= wr_data;
            end

            assign sel_data[gi] = (rd_idx == 4'(gi)) ? entry_reg : 6'd0;
        end
    endgenerate

    always_comb begin
        rd_data = 6'd0;
        for (int i = 0; i < NSTEPS; i++)
            rd_data = rd_data | sel_data[i];
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency sweep sequencer: steps the RF frontend through a table, settling
// and dwelling on each step. Define SWEEP_LOCK_WAIT_EN to wait for VCO lock.
module sweep_sequencer
    import sweep_sequencer_pkg::*;
#(
    parameter logic [6:0] BASE_ADDR = 7'd80,
    parameter int         NSTEPS    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        hb_strobe,
    input  logic        vco_lock,
    output logic [5:0]  rfe_sel,
    output logic        capture_en,
    output logic [3:0]  step_idx,
    output logic        busy,
    output logic        seq_done,
    output logic        lock_err
);

    localparam logic [3:0] NSTEPS_MAX = (NSTEPS > 15) ? 4'd15 : 4'(NSTEPS);

    state_t      state_reg;
    logic [5:0]  rfe_sel_reg;
    logic        capture_en_reg;
    logic [3:0]  step_idx_reg;
    logic        seq_done_reg;
    logic [15:0] settle_cnt_reg;
    logic [15:0] dwell_cnt_reg;

    logic        continuous_reg;
    logic [15:0] settle_reg;
    logic [15:0] dwell_reg;
    logic [3:0]  nsteps_reg;

    logic [5:0]  table_data;
    logic        ctrl_hit;
    logic        start_wr;
    logic        abort_wr;
    logic [3:0]  last_step;
    logic [15:0] dwell_init;
    logic        unused_data_bits;

    assign ctrl_hit   = serial_strobe && (serial_addr == BASE_ADDR + REG_CTRL);
    assign start_wr   = ctrl_hit && serial_data[0];
    assign abort_wr   = ctrl_hit && serial_data[1];
    assign last_step  = clamp_nsteps(nsteps_reg, NSTEPS_MAX) - 4'd1;
    // Down-counter preload: the FSM leaves DWELL on the strobe seen at count 0.
    assign dwell_init = (dwell_reg == 16'd0) ? 16'd0 : dwell_reg - 16'd1;
    assign unused_data_bits = ^serial_data[31:16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            continuous_reg <= 1'b0;
            settle_reg     <= 16'd0;
            dwell_reg      <= 16'd0;
            nsteps_reg     <= 4'd0;
        end else if (serial_strobe) begin
            if (serial_addr == BASE_ADDR + REG_CTRL)
                continuous_reg <= serial_data[2];
            if (serial_addr == BASE_ADDR + REG_SETTLE)
                settle_reg <= serial_data[15:0];
            if (serial_addr == BASE_ADDR + REG_DWELL)
                dwell_reg <= serial_data[15:0];
            if (serial_addr == BASE_ADDR + REG_NSTEPS)
                nsteps_reg <= serial_data[3:0];
        end
    end

    sweep_step_table #(
        .BASE_ADDR (BASE_ADDR),
        .NSTEPS    (NSTEPS)
    ) u_step_table (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (serial_strobe),
        .wr_addr (serial_addr),
        .wr_data (serial_data[5:0]),
        .rd_idx  (step_idx_reg),
        .rd_data (table_data)
    );

`ifdef SWEEP_LOCK_WAIT_EN
    logic        lock_meta_reg;
    logic        lock_sync_reg;
    logic        lock_err_reg;
    logic [15:0] lock_cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            lock_meta_reg <= vco_lock;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    assign lock_err = lock_err_reg;
`else
    logic unused_vco_lock;
    assign unused_vco_lock = vco_lock;
    assign lock_err        = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            rfe_sel_reg    <= 6'd0;
            capture_en_reg <= 1'b0;
            step_idx_reg   <= 4'd0;
            seq_done_reg   <= 1'b0;
            settle_cnt_reg <= 16'd0;
            dwell_cnt_reg  <= 16'd0;
`ifdef SWEEP_LOCK_WAIT_EN
            lock_err_reg   <= 1'b0;
            lock_cnt_reg   <= 16'd0;
`endif
        end else begin
            seq_done_reg <= 1'b0;
            // Abort overrides everything, including a start in the same write.
            if (abort_wr) begin
                state_reg      <= ST_IDLE;
                capture_en_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_wr) begin
                            state_reg    <= ST_LOAD;
                            step_idx_reg <= 4'd0;
`ifdef SWEEP_LOCK_WAIT_EN
                            lock_err_reg <= 1'b0;
`endif
                        end
                    end
                    ST_LOAD: begin
                        rfe_sel_reg    <= table_data;
                        settle_cnt_reg <= settle_reg;
                        state_reg      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_reg == 16'd0) begin
`ifdef SWEEP_LOCK_WAIT_EN
                            state_reg      <= ST_WAIT_LOCK;
                            lock_cnt_reg   <= 16'd0;
`else
                            state_reg      <= ST_DWELL;
                            capture_en_reg <= 1'b1;
                            dwell_cnt_reg  <= dwell_init;
`endif
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg - 16'd1;
                        end
                    end
                    ST_WAIT_LOCK: begin
`ifdef SWEEP_LOCK_WAIT_EN
                        if (lock_sync_reg) begin
                            state_reg      <= ST_DWELL;
                            capture_en_reg <= 1'b1;
                            dwell_cnt_reg  <= dwell_init;
                        end else if (lock_cnt_reg == LOCK_TIMEOUT) begin
                            lock_err_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end else begin
                            lock_cnt_reg <= lock_cnt_reg + 16'd1;
                        end
`else
                        state_reg <= ST_IDLE;
`endif
                    end
                    ST_DWELL: begin
                        if (hb_strobe) begin
                            if (dwell_cnt_reg == 16'd0) begin
                                state_reg      <= ST_NEXT;
                                capture_en_reg <= 1'b0;
                            end else begin
                                dwell_cnt_reg <= dwell_cnt_reg - 16'd1;
                            end
                        end
                    end
                    ST_NEXT: begin
                        if (step_idx_reg == last_step) begin
                            if (continuous_reg) begin
                                step_idx_reg <= 4'd0;
                                state_reg    <= ST_LOAD;
                            end else begin
                                seq_done_reg <= 1'b1;
                                state_reg    <= ST_IDLE;
                            end
                        end else begin
                            step_idx_reg <= step_idx_reg + 4'd1;
                            state_reg    <= ST_LOAD;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign rfe_sel    = rfe_sel_reg;
    assign capture_en = capture_en_reg;
    assign step_idx   = step_idx_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign seq_done   = seq_done_reg;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed self-checking bench for sweep_sequencer; lock-wait checks are
// selected by SWEEP_LOCK_WAIT_EN to match the build of the design.
module tb_sweep_sequencer;

    localparam logic [6:0] BASE = 7'd80;
`ifdef SWEEP_LOCK_WAIT_EN
    localparam int LAT_EXTRA = 1;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        serial_strobe = 1'b0;
    logic [6:0]  serial_addr = 7'd0;
    logic [31:0] serial_data = 32'd0;
    logic        hb_strobe = 1'b0;
    logic        vco_lock = 1'b1;
    logic [5:0]  rfe_sel;
    logic        capture_en;
    logic [3:0]  step_idx;
    logic        busy;
    logic        seq_done;
    logic        lock_err;

    int n_cmp = 0;
    int n_fail = 0;

    int seg_step [16];
    int seg_rfe  [16];
    int seg_strb [16];
    int seg_rise [16];
    int seg_n;
    int done_cnt;
    int ended;

    always #5 clk = ~clk;

    sweep_sequencer dut (
        .clock         (clk),
        .reset         (reset),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .hb_strobe     (hb_strobe),
        .vco_lock      (vco_lock),
        .rfe_sel       (rfe_sel),
        .capture_en    (capture_en),
        .step_idx      (step_idx),
        .busy          (busy),
        .seq_done      (seq_done),
        .lock_err      (lock_err)
    );

    // One-cycle register write; returns one time unit after the consuming edge.
    task automatic wr(input logic [6:0] off, input logic [31:0] d);
        serial_addr   = BASE + off;
        serial_data   = d;
        serial_strobe = 1'b1;
        @(posedge clk);
        #1;
        serial_strobe = 1'b0;
        $display("tb: write addr=%0d data=%0h", BASE + off, d);
    endtask

    task automatic cfg(input int settle, input int dwell, input int nsteps);
        wr(7'd1, 32'(settle));
        wr(7'd2, 32'(dwell));
        wr(7'd3, 32'(nsteps));
    endtask

    // Records each capture window (step, rfe_sel, strobes fed, cycle of rise)
    // while feeding hb_strobe every other cycle inside the window.
    task automatic run_monitor(input int stop_seg, input int budget);
        int cyc;
        bit in_seg;
        bit tog;
        seg_n = 0; done_cnt = 0; ended = 0; cyc = 0;
        in_seg = capture_en; tog = 1'b1;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            hb_strobe = 1'b0;
            if (seq_done) done_cnt++;
            if (!busy) begin
                ended = 1;
                break;
            end
            if (capture_en && !in_seg) begin
                if (seg_n < 16) begin
                    seg_step[seg_n] = int'(step_idx);
                    seg_rfe[seg_n]  = int'(rfe_sel);
                    seg_strb[seg_n] = 0;
                    seg_rise[seg_n] = cyc;
                end
                seg_n++;
                in_seg = 1'b1;
                $display("tb: capture window %0d step=%0d rfe_sel=%0h at cycle %0d", seg_n - 1, step_idx, rfe_sel, cyc);
                if (seg_n == stop_seg) break;
            end
            if (!capture_en) in_seg = 1'b0;
            if (capture_en && tog && seg_n > 0 && seg_n <= 16) begin
                hb_strobe = 1'b1;
                seg_strb[seg_n - 1]++;
            end
            tog = ~tog;
        end
        hb_strobe = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] exp6;
        exp6 = 6'd0;
        n_cmp++; if (rfe_sel !== exp6) begin n_fail++; $display("FAIL reset_rfe_sel: got %0h expected %0h", rfe_sel, exp6); end
        n_cmp++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL reset_capture_en: got %0b expected 0", capture_en); end
        n_cmp++; if (step_idx !== 4'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d expected 0", step_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq_done: got %0b expected 0", seq_done); end
        n_cmp++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL reset_lock_err: got %0b expected 0", lock_err); end
    endtask

    task automatic test_basic;
        int exp_rfe [2];
        exp_rfe = '{32'h05, 32'h2A};
        cfg(3, 4, 2);
        wr(7'd4, 32'h05);
        wr(7'd5, 32'h2A);
        wr(7'd0, 32'h1);
        run_monitor(99, 400);
        n_cmp++; if (seg_n != 2) begin n_fail++; $display("FAIL basic_windows: got %0d expected 2", seg_n); end
        n_cmp++; if (seg_rise[0] != 5 + LAT_EXTRA) begin n_fail++; $display("FAIL basic_first_capture_latency: got %0d expected %0d", seg_rise[0], 5 + LAT_EXTRA); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (seg_step[i] != i) begin n_fail++; $display("FAIL basic_step%0d_idx: got %0d expected %0d", i, seg_step[i], i); end
            n_cmp++; if (seg_rfe[i] != exp_rfe[i]) begin n_fail++; $display("FAIL basic_step%0d_rfe_sel: got %0h expected %0h", i, seg_rfe[i], exp_rfe[i]); end
            n_cmp++; if (seg_strb[i] != 4) begin n_fail++; $display("FAIL basic_step%0d_strobes: got %0d expected 4", i, seg_strb[i]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_seq_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (ended != 1) begin n_fail++; $display("FAIL basic_busy_fall: got %0d expected 1", ended); end
        @(posedge clk); #1;
        n_cmp++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL basic_seq_done_width: got %0b expected 0", seq_done); end
    endtask

    task automatic test_continuous;
        int exp_step [5];
        exp_step = '{0, 1, 2, 0, 1};
        cfg(1, 2, 3);
        wr(7'd6, 32'h33);
        wr(7'd0, 32'h5);
        run_monitor(5, 600);
        n_cmp++; if (seg_n != 5) begin n_fail++; $display("FAIL cont_windows: got %0d expected 5", seg_n); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (seg_step[i] != exp_step[i]) begin n_fail++; $display("FAIL cont_step_seq%0d: got %0d expected %0d", i, seg_step[i], exp_step[i]); end
        end
        n_cmp++; if (seg_strb[2] != 2) begin n_fail++; $display("FAIL cont_strobes: got %0d expected 2", seg_strb[2]); end
        n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL cont_no_seq_done: got %0d expected 0", done_cnt); end
        wr(7'd0, 32'h2);
        n_cmp++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL abort_capture_en: got %0b expected 0", capture_en); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        n_cmp++; if (rfe_sel !== 6'h2A) begin n_fail++; $display("FAIL abort_rfe_hold: got %0h expected 2a", rfe_sel); end
        n_cmp++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL abort_seq_done: got %0b expected 0", seq_done); end
    endtask

    task automatic test_boundary;
        cfg(0, 0, 0);
        wr(7'd4, 32'h11);
        wr(7'd0, 32'h1);
        run_monitor(99, 100);
        n_cmp++; if (seg_n != 1) begin n_fail++; $display("FAIL bound_windows: got %0d expected 1", seg_n); end
        n_cmp++; if (seg_rise[0] != 2 + LAT_EXTRA) begin n_fail++; $display("FAIL bound_settle_latency: got %0d expected %0d", seg_rise[0], 2 + LAT_EXTRA); end
        n_cmp++; if (seg_strb[0] != 1) begin n_fail++; $display("FAIL bound_strobes: got %0d expected 1", seg_strb[0]); end
        n_cmp++; if (seg_rfe[0] != 32'h11) begin n_fail++; $display("FAIL bound_rfe_sel: got %0h expected 11", seg_rfe[0]); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL bound_seq_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_clamp;
        cfg(0, 1, 15);
        wr(7'd0, 32'h1);
        run_monitor(99, 400);
        n_cmp++; if (seg_n != 8) begin n_fail++; $display("FAIL clamp_windows: got %0d expected 8", seg_n); end
        n_cmp++; if (seg_step[7] != 7) begin n_fail++; $display("FAIL clamp_last_step: got %0d expected 7", seg_step[7]); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL clamp_seq_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_abort;
        wr(7'd0, 32'h3);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %0b expected 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle: got %0b expected 0", busy); end
        n_cmp++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL start_abort_capture: got %0b expected 0", capture_en); end
    endtask

    task automatic test_start_busy;
        cfg(2, 2, 2);
        wr(7'd0, 32'h1);
        run_monitor(2, 200);
        n_cmp++; if (seg_n != 2) begin n_fail++; $display("FAIL busy_start_reach_step1: got %0d expected 2", seg_n); end
        wr(7'd0, 32'h1);
        n_cmp++; if (step_idx !== 4'd1) begin n_fail++; $display("FAIL busy_start_step_idx: got %0d expected 1", step_idx); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy: got %0b expected 1", busy); end
        n_cmp++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL busy_start_capture: got %0b expected 1", capture_en); end
        wr(7'd0, 32'h2);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_abort: got %0b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int exp_rfe [2];
        exp_rfe = '{32'h07, 32'h08};
        cfg(3, 4, 2);
        wr(7'd4, 32'h05);
        wr(7'd0, 32'h1);
        run_monitor(1, 100);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL midreset_capture: got %0b expected 0", capture_en); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
        n_cmp++; if (rfe_sel !== 6'd0) begin n_fail++; $display("FAIL midreset_rfe_sel: got %0h expected 0", rfe_sel); end
        n_cmp++; if (step_idx !== 4'd0) begin n_fail++; $display("FAIL midreset_step_idx: got %0d expected 0", step_idx); end
        n_cmp++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL midreset_seq_done: got %0b expected 0", seq_done); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("tb: reset released after mid-sweep assertion");
        cfg(0, 1, 2);
        wr(7'd4, 32'h07);
        wr(7'd5, 32'h08);
        wr(7'd0, 32'h1);
        run_monitor(99, 200);
        n_cmp++; if (seg_n != 2) begin n_fail++; $display("FAIL rerun_windows: got %0d expected 2", seg_n); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (seg_step[i] != i) begin n_fail++; $display("FAIL rerun_step%0d_idx: got %0d expected %0d", i, seg_step[i], i); end
            n_cmp++; if (seg_rfe[i] != exp_rfe[i]) begin n_fail++; $display("FAIL rerun_step%0d_rfe_sel: got %0h expected %0h", i, seg_rfe[i], exp_rfe[i]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL rerun_seq_done: got %0d expected 1", done_cnt); end
    endtask

`ifdef SWEEP_LOCK_WAIT_EN
    task automatic test_lock_wait;
        int cyc;
        cfg(0, 1, 1);
        vco_lock = 1'b0;
        wr(7'd0, 32'h1);
        cyc = 0;
        while (busy && cyc < 70000) begin
            @(posedge clk); #1; cyc++;
        end
        $display("tb: lock timeout sweep ended after %0d cycles", cyc);
        n_cmp++; if (lock_err !== 1'b1) begin n_fail++; $display("FAIL lock_timeout_err: got %0b expected 1", lock_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_timeout_idle: got %0b expected 0", busy); end
        n_cmp++; if (cyc < 65535 || cyc > 65545) begin n_fail++; $display("FAIL lock_timeout_cycles: got %0d expected 65535..65545", cyc); end
        wr(7'd0, 32'h1);
        n_cmp++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL lock_err_clear: got %0b expected 0", lock_err); end
        repeat (10) @(posedge clk);
        #1;
        vco_lock = 1'b1;
        cyc = 0;
        while (!capture_en && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        n_cmp++; if (cyc < 2 || cyc > 3) begin n_fail++; $display("FAIL lock_to_dwell: got %0d cycles expected 2..3", cyc); end
        wr(7'd0, 32'h2);
    endtask
`else
    task automatic test_lock_tied;
        vco_lock = 1'b0;
        cfg(0, 1, 1);
        wr(7'd0, 32'h1);
        run_monitor(99, 100);
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL nolock_sweep_done: got %0d expected 1", done_cnt); end
        n_cmp++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL nolock_lock_err: got %0b expected 0", lock_err); end
        vco_lock = 1'b1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset;
        test_basic;
        test_continuous;
        test_boundary;
        test_clamp;
        test_start_abort;
        test_start_busy;
        test_reset_mid;
`ifdef SWEEP_LOCK_WAIT_EN
        test_lock_wait;
`else
        test_lock_tied;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
